// File: rtl/sram_axi_bridge_pkg.sv
// Shared definitions for the sram-like to AXI bridge: FSM encodings, default IDs
// and the fixed AXI attribute values driven on every single-beat transfer.
package sram_axi_bridge_pkg;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_AR   = 2'd1,
    RD_R    = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_AWW  = 2'd1,
    WR_B    = 2'd2
  } wr_state_t;

  localparam logic [3:0] INST_ID_DEF = 4'd0;
  localparam logic [3:0] DATA_ID_DEF = 4'd1;

  localparam logic [7:0] AXI_LEN   = 8'd0;
  localparam logic [1:0] AXI_BURST = 2'b01;
  localparam logic [1:0] AXI_LOCK  = 2'b00;
  localparam logic [3:0] AXI_CACHE = 4'd0;
  localparam logic [2:0] AXI_PROT  = 3'd0;

  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/sram_axi_bridge_wr_fsm.sv
// Write channel engine for data-port stores: issues AW and W together, retires
// each independently, then waits for the B response.
module bridge_wr_fsm
  import sram_axi_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        accept,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  input  logic        awready,
  input  logic        wready,
  input  logic        bvalid,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  output logic        bready,
  output logic        busy,
  output logic        data_ok
);

  wr_state_t   state, state_next;
  logic        aw_done, w_done;
  logic [1:0]  size_q;

  assign awsize = axi_size(size_q);
  assign busy   = (state != WR_IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= WR_IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      awaddr  <= 32'd0;
      size_q  <= 2'd0;
      wstrb   <= 4'd0;
      wdata   <= 32'd0;
    end else begin
      state <= state_next;
      if (state == WR_IDLE && accept) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        awaddr  <= req_addr;
        size_q  <= req_size;
        wstrb   <= req_wstrb;
        wdata   <= req_wdata;
      end else begin
        if (awvalid && awready) aw_done <= 1'b1;
        if (wvalid && wready)   w_done  <= 1'b1;
      end
    end
  end

  // A same-cycle handshake counts as done, so both channels can retire together.
  always_comb begin
    state_next = state;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    data_ok    = 1'b0;
    if (resetn) begin
      case (state)
        WR_IDLE: if (accept) state_next = WR_AWW;
        WR_AWW: begin
          awvalid = !aw_done;
          wvalid  = !w_done;
          if ((aw_done || awready) && (w_done || wready)) state_next = WR_B;
        end
        WR_B: begin
          bready = 1'b1;
          if (bvalid) begin
            data_ok    = 1'b1;
            state_next = WR_IDLE;
          end
        end
        default: state_next = WR_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sram_axi_bridge.sv
// Arbitrates the inst-fetch and data sram-like ports onto one AXI master; one shared
// read engine (data reads first) plus an independent store engine.
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
#(
  parameter logic [3:0] INST_ID = INST_ID_DEF,
  parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  rd_state_t   rd_state, rd_next;
  logic        rd_is_data;
  logic [31:0] rd_addr;
  logic [1:0]  rd_size;
  logic        data_busy, data_rd_grant, inst_grant, data_rd_ok;
  logic        wr_accept, wr_busy, wr_data_ok;

  assign arid    = rd_is_data ? DATA_ID : INST_ID;
  assign araddr  = rd_addr;
  assign arsize  = axi_size(rd_size);
  assign arlen   = AXI_LEN;
  assign arburst = AXI_BURST;
  assign arlock  = AXI_LOCK;
  assign arcache = AXI_CACHE;
  assign arprot  = AXI_PROT;
  assign awid    = DATA_ID;
  assign awlen   = AXI_LEN;
  assign awburst = AXI_BURST;
  assign awlock  = AXI_LOCK;
  assign awcache = AXI_CACHE;
  assign awprot  = AXI_PROT;
  assign wid     = DATA_ID;
  assign wlast   = 1'b1;

  // One data op in flight at a time keeps data-port ordering trivially correct.
  assign data_busy = wr_busy || (rd_state != RD_IDLE && rd_is_data);

  assign inst_sram_addr_ok = inst_grant;
  assign data_sram_addr_ok = data_rd_grant || wr_accept;
  assign data_sram_data_ok = data_rd_ok || wr_data_ok;
  assign inst_sram_rdata   = rdata;
  assign data_sram_rdata   = rdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_state   <= RD_IDLE;
      rd_is_data <= 1'b0;
      rd_addr    <= 32'd0;
      rd_size    <= 2'd0;
    end else begin
      rd_state <= rd_next;
      if (data_rd_grant) begin
        rd_is_data <= 1'b1;
        rd_addr    <= data_sram_addr;
        rd_size    <= data_sram_size;
      end else if (inst_grant) begin
        rd_is_data <= 1'b0;
        rd_addr    <= inst_sram_addr;
        rd_size    <= 2'd2;
      end
    end
  end

  // Routing follows the owner register; rid only has to agree with it.
  always_ff @(posedge clk) begin
    if (resetn && rd_state == RD_R && rvalid) assert (rid == arid);
  end

  always_comb begin
    rd_next           = rd_state;
    data_rd_grant     = 1'b0;
    inst_grant        = 1'b0;
    wr_accept         = 1'b0;
    arvalid           = 1'b0;
    rready            = 1'b0;
    data_rd_ok        = 1'b0;
    inst_sram_data_ok = 1'b0;
    if (resetn) begin
      wr_accept = data_sram_req && data_sram_wr && !data_busy;
      case (rd_state)
        RD_IDLE: begin
          if (data_sram_req && !data_sram_wr && !data_busy) begin
            data_rd_grant = 1'b1;
            rd_next       = RD_AR;
          end else if (inst_sram_req) begin
            inst_grant = 1'b1;
            rd_next    = RD_AR;
          end
        end
        RD_AR: begin
          arvalid = 1'b1;
          if (arready) rd_next = RD_R;
        end
        RD_R: begin
          rready = 1'b1;
          if (rvalid) begin
            rd_next = RD_IDLE;
            if (rd_is_data) data_rd_ok = 1'b1;
            else            inst_sram_data_ok = 1'b1;
          end
        end
        default: rd_next = RD_IDLE;
      endcase
    end
  end

  bridge_wr_fsm u_wr_fsm (
    .clk       (clk),
    .resetn    (resetn),
    .accept    (wr_accept),
    .req_addr  (data_sram_addr),
    .req_size  (data_sram_size),
    .req_wstrb (data_sram_wstrb),
    .req_wdata (data_sram_wdata),
    .awready   (awready),
    .wready    (wready),
    .bvalid    (bvalid),
    .awaddr    (awaddr),
    .awsize    (awsize),
    .awvalid   (awvalid),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wvalid    (wvalid),
    .bready    (bready),
    .busy      (wr_busy),
    .data_ok   (wr_data_ok)
  );

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed scenario bench for sram_axi_bridge: the bench plays both the CPU ports
// and the AXI slave cycle by cycle, with expected values worked out by hand.
module tb_sram_axi_bridge;

  logic        clk, resetn;
  logic        inst_sram_req, inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_addr, inst_sram_rdata;
  logic        data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic [3:0]  data_sram_wstrb;
  logic [3:0]  arid, rid, awid, wid, arcache, awcache, wstrb;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock;
  logic        arvalid, arready, rvalid, rready, awvalid, awready;
  logic        wlast, wvalid, wready, bvalid, bready;

  int total = 0;
  int bad   = 0;

  sram_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change 1 ns after the rising edge; outputs are read 1 ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    inst_sram_req = 0; inst_sram_addr = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 0;
    data_sram_addr = 0; data_sram_wstrb = 0; data_sram_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rvalid = 0;
    awready = 0; wready = 0; bvalid = 0;
  endtask

  task automatic test_reset();
    logic [8:0] hs;
    resetn = 1'b0;
    drive_idle();
    inst_sram_req = 1; data_sram_req = 1;
    repeat (3) cyc();
    #1;
    hs = {arvalid, rready, awvalid, wvalid, bready, inst_sram_addr_ok,
          data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok};
    total++; if (hs !== 9'b0) begin bad++; $display("[TB] FAIL reset_handshakes: got %b want %b", hs, 9'b0); end
    total++; if (araddr !== 32'd0) begin bad++; $display("[TB] FAIL reset_araddr: got %h want 0", araddr); end
    total++; if (awaddr !== 32'd0) begin bad++; $display("[TB] FAIL reset_awaddr: got %h want 0", awaddr); end
    total++; if (arid !== 4'd0) begin bad++; $display("[TB] FAIL reset_arid: got %0d want 0", arid); end
    total++; if ({awid, wlast, arburst, awlen} !== {4'd1, 1'b1, 2'b01, 8'd0}) begin
      bad++; $display("[TB] FAIL tieoffs: got awid=%0d wlast=%b arburst=%b awlen=%0d", awid, wlast, arburst, awlen);
    end
    cyc();
    resetn = 1'b1;
    drive_idle();
  endtask

  task automatic test_inst_read();
    cyc();
    inst_sram_req = 1; inst_sram_addr = 32'h1c00_0000; arready = 1;
    #1;
    total++; if (inst_sram_addr_ok !== 1'b1 || arvalid !== 1'b0) begin
      bad++; $display("[TB] FAIL inst_accept: got addr_ok=%b arvalid=%b want 1 0", inst_sram_addr_ok, arvalid);
    end
    cyc();
    inst_sram_req = 0;
    #1;
    total++; if ({arvalid, araddr, arid, arsize} !== {1'b1, 32'h1c00_0000, 4'd0, 3'd2}) begin
      bad++; $display("[TB] FAIL inst_ar: got v=%b addr=%h id=%0d size=%0d want 1 1c000000 0 2", arvalid, araddr, arid, arsize);
    end
    total++; if (inst_sram_data_ok !== 1'b0) begin bad++; $display("[TB] FAIL inst_early_ok: got %b want 0", inst_sram_data_ok); end
    cyc();
    arready = 0; rvalid = 1; rid = 0; rdata = 32'h02c0_0000;
    #1;
    total++; if ({rready, inst_sram_data_ok, data_sram_data_ok} !== 3'b110 || inst_sram_rdata !== 32'h02c0_0000) begin
      bad++; $display("[TB] FAIL inst_data: got rready=%b iok=%b dok=%b rdata=%h want 1 1 0 02c00000",
                      rready, inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata);
    end
    cyc();
    rvalid = 0;
    #1;
    total++; if ({rready, inst_sram_data_ok} !== 2'b00) begin
      bad++; $display("[TB] FAIL inst_done: got rready=%b iok=%b want 0 0", rready, inst_sram_data_ok);
    end
  endtask

  task automatic test_priority();
    cyc();
    inst_sram_req = 1; inst_sram_addr = 32'h1c00_0004;
    data_sram_req = 1; data_sram_wr = 0; data_sram_size = 2; data_sram_addr = 32'h8000_0010;
    #1;
    total++; if ({data_sram_addr_ok, inst_sram_addr_ok} !== 2'b10) begin
      bad++; $display("[TB] FAIL prio_grant: got d=%b i=%b want 1 0", data_sram_addr_ok, inst_sram_addr_ok);
    end
    cyc();
    data_sram_req = 0; arready = 1;
    #1;
    total++; if ({arvalid, araddr, arid, inst_sram_addr_ok} !== {1'b1, 32'h8000_0010, 4'd1, 1'b0}) begin
      bad++; $display("[TB] FAIL prio_ar: got v=%b addr=%h id=%0d iaok=%b want 1 80000010 1 0", arvalid, araddr, arid, inst_sram_addr_ok);
    end
    cyc();
    arready = 0; rvalid = 1; rid = 1; rdata = 32'h1122_3344;
    #1;
    total++; if ({data_sram_data_ok, inst_sram_data_ok, inst_sram_addr_ok} !== 3'b100 || data_sram_rdata !== 32'h1122_3344) begin
      bad++; $display("[TB] FAIL prio_data: got dok=%b iok=%b iaok=%b rdata=%h want 1 0 0 11223344",
                      data_sram_data_ok, inst_sram_data_ok, inst_sram_addr_ok, data_sram_rdata);
    end
    cyc();
    rvalid = 0;
    #1;
    total++; if (inst_sram_addr_ok !== 1'b1) begin bad++; $display("[TB] FAIL prio_inst_later: got %b want 1", inst_sram_addr_ok); end
    cyc();
    inst_sram_req = 0; arready = 1;
    #1;
    total++; if ({arvalid, araddr, arid} !== {1'b1, 32'h1c00_0004, 4'd0}) begin
      bad++; $display("[TB] FAIL prio_inst_ar: got v=%b addr=%h id=%0d want 1 1c000004 0", arvalid, araddr, arid);
    end
    cyc();
    arready = 0; rvalid = 1; rid = 0; rdata = 32'h0000_0055;
    #1;
    total++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b10) begin
      bad++; $display("[TB] FAIL prio_inst_data: got iok=%b dok=%b want 1 0", inst_sram_data_ok, data_sram_data_ok);
    end
    cyc();
    drive_idle();
  endtask

  task automatic test_write();
    int aw_cnt = 0, w_cnt = 0;
    cyc();
    data_sram_req = 1; data_sram_wr = 1; data_sram_size = 1; data_sram_addr = 32'h8000_0020;
    data_sram_wstrb = 4'h3; data_sram_wdata = 32'ha5a5_1234; wready = 1;
    #1;
    total++; if ({data_sram_addr_ok, awvalid, wvalid} !== 3'b100) begin
      bad++; $display("[TB] FAIL wr_accept: got aok=%b aw=%b w=%b want 1 0 0", data_sram_addr_ok, awvalid, wvalid);
    end
    for (int i = 1; i <= 6; i++) begin
      cyc();
      data_sram_req = 0; awready = (i == 4); bvalid = (i == 5);
      #1;
      aw_cnt += int'(awvalid);
      w_cnt  += int'(wvalid);
      if (i == 1) begin
        total++; if ({awaddr, awsize, wstrb, wdata} !== {32'h8000_0020, 3'd1, 4'h3, 32'ha5a5_1234}) begin
          bad++; $display("[TB] FAIL wr_payload: got %h %0d %h %h want 80000020 1 3 a5a51234", awaddr, awsize, wstrb, wdata);
        end
      end
      total++; if (data_sram_data_ok !== (i == 5)) begin
        bad++; $display("[TB] FAIL wr_data_ok cycle %0d: got %b want %b", i, data_sram_data_ok, (i == 5));
      end
      if (i == 5) begin
        total++; if ({bready, awvalid, wvalid} !== 3'b100) begin
          bad++; $display("[TB] FAIL wr_b: got b=%b aw=%b w=%b want 1 0 0", bready, awvalid, wvalid);
        end
      end
    end
    total++; if (aw_cnt != 4 || w_cnt != 1) begin
      bad++; $display("[TB] FAIL wr_valid_len: got aw=%0d w=%0d want 4 1", aw_cnt, w_cnt);
    end
    cyc();
    drive_idle();
  endtask

  task automatic test_overlap();
    int iok_cnt = 0, dok_cnt = 0;
    cyc();
    data_sram_req = 1; data_sram_wr = 1; data_sram_size = 2; data_sram_addr = 32'h8000_0030;
    data_sram_wstrb = 4'hf; data_sram_wdata = 32'hdead_beef;
    inst_sram_req = 1; inst_sram_addr = 32'h1c00_0008;
    awready = 1; wready = 1; arready = 1;
    #1;
    total++; if ({data_sram_addr_ok, inst_sram_addr_ok} !== 2'b11) begin
      bad++; $display("[TB] FAIL ovl_grant: got d=%b i=%b want 1 1", data_sram_addr_ok, inst_sram_addr_ok);
    end
    cyc();
    data_sram_req = 0; inst_sram_req = 0;
    #1;
    total++; if ({awvalid, wvalid, arvalid, araddr, arid} !== {3'b111, 32'h1c00_0008, 4'd0}) begin
      bad++; $display("[TB] FAIL ovl_issue: got aw=%b w=%b ar=%b addr=%h id=%0d", awvalid, wvalid, arvalid, araddr, arid);
    end
    for (int i = 2; i <= 9; i++) begin
      cyc();
      awready = 0; wready = 0; arready = 0;
      data_sram_req = 1; data_sram_wr = 0; data_sram_size = 2; data_sram_addr = 32'h8000_0040;
      rvalid = (i == 2); rid = 0; rdata = 32'h0bad_f00d; bvalid = (i == 8);
      #1;
      iok_cnt += int'(inst_sram_data_ok);
      dok_cnt += int'(data_sram_data_ok);
      total++; if ({inst_sram_data_ok, data_sram_data_ok, data_sram_addr_ok} !== {(i == 2), (i == 8), (i == 9)}) begin
        bad++; $display("[TB] FAIL ovl_cycle %0d: got iok=%b dok=%b daok=%b want %b %b %b", i,
                        inst_sram_data_ok, data_sram_data_ok, data_sram_addr_ok, (i == 2), (i == 8), (i == 9));
      end
      if (i == 2) begin
        total++; if (inst_sram_rdata !== 32'h0bad_f00d) begin bad++; $display("[TB] FAIL ovl_irdata: got %h want 0badf00d", inst_sram_rdata); end
      end
    end
    total++; if (iok_cnt != 1 || dok_cnt != 1) begin
      bad++; $display("[TB] FAIL ovl_counts: got iok=%0d dok=%0d want 1 1", iok_cnt, dok_cnt);
    end
    cyc();
    data_sram_req = 0; bvalid = 0; arready = 1;
    #1;
    total++; if ({arvalid, araddr, arid} !== {1'b1, 32'h8000_0040, 4'd1}) begin
      bad++; $display("[TB] FAIL ovl_dread_ar: got v=%b addr=%h id=%0d want 1 80000040 1", arvalid, araddr, arid);
    end
    cyc();
    arready = 0; rvalid = 1; rid = 1; rdata = 32'h600d_cafe;
    #1;
    total++; if (data_sram_data_ok !== 1'b1 || data_sram_rdata !== 32'h600d_cafe) begin
      bad++; $display("[TB] FAIL ovl_dread_data: got dok=%b rdata=%h want 1 600dcafe", data_sram_data_ok, data_sram_rdata);
    end
    cyc();
    drive_idle();
    #1;
    total++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin
      bad++; $display("[TB] FAIL ovl_quiet: got iok=%b dok=%b want 0 0", inst_sram_data_ok, data_sram_data_ok);
    end
  endtask

  task automatic test_late_rvalid();
    cyc();
    inst_sram_req = 1; inst_sram_addr = 32'h1c00_000c; arready = 1;
    #1;
    total++; if (inst_sram_addr_ok !== 1'b1) begin bad++; $display("[TB] FAIL late_accept: got %b want 1", inst_sram_addr_ok); end
    cyc();
    inst_sram_req = 0;
    #1;
    total++; if (arvalid !== 1'b1 || araddr !== 32'h1c00_000c) begin
      bad++; $display("[TB] FAIL late_ar: got v=%b addr=%h want 1 1c00000c", arvalid, araddr);
    end
    for (int i = 2; i <= 7; i++) begin
      cyc();
      arready = 0; inst_sram_req = 1; inst_sram_addr = 32'h1c00_0010;
      rvalid = (i == 7); rid = 0; rdata = 32'h1234_5678;
      #1;
      total++; if ({arvalid, rready, inst_sram_addr_ok, inst_sram_data_ok} !== {3'b010, (i == 7)}) begin
        bad++; $display("[TB] FAIL late_wait %0d: got ar=%b r=%b iaok=%b iok=%b want 0 1 0 %b", i,
                        arvalid, rready, inst_sram_addr_ok, inst_sram_data_ok, (i == 7));
      end
    end
    cyc();
    rvalid = 0;
    #1;
    total++; if ({inst_sram_addr_ok, rready} !== 2'b10) begin
      bad++; $display("[TB] FAIL late_next_grant: got iaok=%b r=%b want 1 0", inst_sram_addr_ok, rready);
    end
    cyc();
    inst_sram_req = 0; arready = 1;
    #1;
    total++; if (arvalid !== 1'b1 || araddr !== 32'h1c00_0010) begin
      bad++; $display("[TB] FAIL late_next_ar: got v=%b addr=%h want 1 1c000010", arvalid, araddr);
    end
    cyc();
    arready = 0; rvalid = 1; rid = 0; rdata = 32'h9abc_def0;
    #1;
    total++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'h9abc_def0) begin
      bad++; $display("[TB] FAIL late_next_data: got iok=%b rdata=%h want 1 9abcdef0", inst_sram_data_ok, inst_sram_rdata);
    end
    cyc();
    drive_idle();
  endtask

  task automatic test_reset_mid();
    cyc();
    inst_sram_req = 1; inst_sram_addr = 32'h1c00_0020; arready = 1;
    cyc();
    inst_sram_req = 0;
    #1;
    total++; if (arvalid !== 1'b1) begin bad++; $display("[TB] FAIL rst_mid_ar: got %b want 1", arvalid); end
    cyc();
    arready = 0; resetn = 0; rvalid = 1; rid = 0; rdata = 32'hffff_ffff;
    #1;
    total++; if ({inst_sram_data_ok, rready} !== 2'b00) begin
      bad++; $display("[TB] FAIL rst_mid_drop: got iok=%b r=%b want 0 0", inst_sram_data_ok, rready);
    end
    cyc();
    resetn = 1; rvalid = 0; inst_sram_req = 1; inst_sram_addr = 32'h1c00_0024; arready = 1;
    #1;
    total++; if ({arvalid, rready, awvalid, wvalid, bready, inst_sram_data_ok, data_sram_data_ok} !== 7'b0) begin
      bad++; $display("[TB] FAIL rst_mid_idle: got ar=%b r=%b aw=%b w=%b b=%b iok=%b dok=%b want all 0",
                      arvalid, rready, awvalid, wvalid, bready, inst_sram_data_ok, data_sram_data_ok);
    end
    total++; if (inst_sram_addr_ok !== 1'b1) begin bad++; $display("[TB] FAIL rst_mid_regrant: got %b want 1", inst_sram_addr_ok); end
    cyc();
    inst_sram_req = 0;
    #1;
    total++; if (arvalid !== 1'b1 || araddr !== 32'h1c00_0024) begin
      bad++; $display("[TB] FAIL rst_mid_ar2: got v=%b addr=%h want 1 1c000024", arvalid, araddr);
    end
    cyc();
    arready = 0; rvalid = 1; rid = 0; rdata = 32'h0000_beef;
    #1;
    total++; if (inst_sram_data_ok !== 1'b1 || inst_sram_rdata !== 32'h0000_beef) begin
      bad++; $display("[TB] FAIL rst_mid_data: got iok=%b rdata=%h want 1 0000beef", inst_sram_data_ok, inst_sram_rdata);
    end
    cyc();
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_inst_read();
    test_priority();
    test_write();
    test_overlap();
    test_late_rvalid();
    test_reset_mid();
    repeat (2) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
